// File: rtl/framebuffer_scanout_pkg.sv
// Shared video types (colors, points, triangles) and the default 640x480 display timing.
package framebuffer_scanout_pkg;

    localparam int unsigned COLOR_BITS = 16;
    localparam int unsigned COORD_BITS = 12;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    typedef logic [COLOR_BITS-1:0] color_t;

    typedef struct packed {
        logic [COORD_BITS-1:0] x;
        logic [COORD_BITS-1:0] y;
    } point_t;

    typedef struct packed {
        point_t a;
        point_t b;
        point_t c;
        color_t color;
    } triangle_t;

    // Per-position control flags carried down the scanout pipeline
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic frame_start;
        logic in_image;
    } scan_flags_t;

    localparam scan_flags_t SCAN_FLAGS_IDLE = '{
        hsync: 1'b1, vsync: 1'b1, de: 1'b0, frame_start: 1'b0, in_image: 1'b0
    };

endpackage

// File: rtl/sync_timing_gen.sv
// Raster h/v counters with active-area and raw sync decode for the current position.
module sync_timing_gen
    import framebuffer_scanout_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic line_end_c,
    output logic frame_end_c,
    output logic origin_c,
    output logic active_c,
    output logic active_nxt_c,
    output logic hsync_c,
    output logic vsync_c
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned HS_BEGIN = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_BEGIN + H_SYNC;
    localparam int unsigned VS_BEGIN = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_BEGIN + V_SYNC;

    logic [HW-1:0] h_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Next position plus decode of both the current and the next position
    always_comb begin
        line_end_c   = (32'(h_cnt) == H_TOTAL - 32'd1);
        frame_end_c  = line_end_c && (32'(v_cnt) == V_TOTAL - 32'd1);
        h_nxt        = line_end_c ? '0 : h_cnt + HW'(1);
        v_nxt        = v_cnt;
        if (line_end_c) begin
            v_nxt = frame_end_c ? '0 : v_cnt + VW'(1);
        end
        origin_c     = (h_cnt == '0) && (v_cnt == '0);
        active_c     = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
        active_nxt_c = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
        hsync_c      = !((32'(h_cnt) >= HS_BEGIN) && (32'(h_cnt) < HS_END));
        vsync_c      = !((32'(v_cnt) >= VS_BEGIN) && (32'(v_cnt) < VS_END));
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Raster scanout of a framebuffer with integer pixel replication, border fill and clipping.
module framebuffer_scanout
    import framebuffer_scanout_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH         = 100,
    parameter int unsigned DISPLAY_HEIGHT        = 100,
    parameter int unsigned SCALE                 = 4,
    parameter int unsigned FRAMEBUFFER_DATA_BITS = COLOR_BITS,
    parameter int unsigned FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT),
    parameter int unsigned H_ACTIVE              = H_ACTIVE_DEF,
    parameter int unsigned H_FP                  = H_FP_DEF,
    parameter int unsigned H_SYNC                = H_SYNC_DEF,
    parameter int unsigned H_BP                  = H_BP_DEF,
    parameter int unsigned V_ACTIVE              = V_ACTIVE_DEF,
    parameter int unsigned V_FP                  = V_FP_DEF,
    parameter int unsigned V_SYNC                = V_SYNC_DEF,
    parameter int unsigned V_BP                  = V_BP_DEF,
    parameter logic [FRAMEBUFFER_DATA_BITS-1:0] BORDER_COLOR = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] fb_rd_addr,
    input  logic [FRAMEBUFFER_DATA_BITS-1:0] fb_rd_data,
    output logic                             hsync,
    output logic                             vsync,
    output logic                             de,
    output logic [FRAMEBUFFER_DATA_BITS-1:0] pixel_out,
    output logic                             frame_start
);

    localparam int unsigned AW = FRAMEBUFFER_ADDR_BITS;
    localparam int unsigned XW = $clog2(DISPLAY_WIDTH + 1);
    localparam int unsigned YW = $clog2(DISPLAY_HEIGHT + 1);
    localparam int unsigned SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

    logic line_end_c;
    logic frame_end_c;
    logic origin_c;
    logic active_c;
    logic active_nxt_c;
    logic hsync_c;
    logic vsync_c;

    logic [SW-1:0] sub_x, sub_x_nxt;
    logic [SW-1:0] sub_y, sub_y_nxt;
    logic [XW-1:0] fb_x, fb_x_nxt;
    logic [YW-1:0] fb_y, fb_y_nxt;
    logic [AW-1:0] row_base, row_base_nxt;
    logic          in_image_nxt;
    scan_flags_t   cur_flags_c;
    scan_flags_t   flags_s1;

    sync_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .line_end_c   (line_end_c),
        .frame_end_c  (frame_end_c),
        .origin_c     (origin_c),
        .active_c     (active_c),
        .active_nxt_c (active_nxt_c),
        .hsync_c      (hsync_c),
        .vsync_c      (vsync_c)
    );

    // Sub-pixel stepping of fb_x/fb_y; both saturate one past the image edge
    always_comb begin
        sub_x_nxt    = sub_x;
        sub_y_nxt    = sub_y;
        fb_x_nxt     = fb_x;
        fb_y_nxt     = fb_y;
        row_base_nxt = row_base;
        if (line_end_c) begin
            sub_x_nxt = '0;
            fb_x_nxt  = '0;
            if (frame_end_c) begin
                sub_y_nxt    = '0;
                fb_y_nxt     = '0;
                row_base_nxt = '0;
            end else if (sub_y == SUB_LAST) begin
                sub_y_nxt = '0;
                if (32'(fb_y) < DISPLAY_HEIGHT) begin
                    fb_y_nxt = fb_y + YW'(1);
                end
                // row_base only ever names a real image row, keeping the address in range
                if (32'(fb_y) + 32'd1 < DISPLAY_HEIGHT) begin
                    row_base_nxt = row_base + AW'(DISPLAY_WIDTH);
                end
            end else begin
                sub_y_nxt = sub_y + SW'(1);
            end
        end else if (sub_x == SUB_LAST) begin
            sub_x_nxt = '0;
            if (32'(fb_x) < DISPLAY_WIDTH) begin
                fb_x_nxt = fb_x + XW'(1);
            end
        end else begin
            sub_x_nxt = sub_x + SW'(1);
        end

        in_image_nxt = active_nxt_c && (32'(fb_x_nxt) < DISPLAY_WIDTH)
                       && (32'(fb_y_nxt) < DISPLAY_HEIGHT);

        cur_flags_c = '{
            hsync:       hsync_c,
            vsync:       vsync_c,
            de:          active_c,
            frame_start: origin_c,
            in_image:    active_c && (32'(fb_x) < DISPLAY_WIDTH)
                         && (32'(fb_y) < DISPLAY_HEIGHT)
        };
    end

    // Address is issued with its position; flags wait one clk for read data, then register out
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_x       <= '0;
            sub_y       <= '0;
            fb_x        <= '0;
            fb_y        <= '0;
            row_base    <= '0;
            fb_rd_addr  <= '0;
            flags_s1    <= SCAN_FLAGS_IDLE;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
            pixel_out   <= '0;
        end else begin
            sub_x       <= sub_x_nxt;
            sub_y       <= sub_y_nxt;
            fb_x        <= fb_x_nxt;
            fb_y        <= fb_y_nxt;
            row_base    <= row_base_nxt;
            if (in_image_nxt) begin
                fb_rd_addr <= row_base_nxt + AW'(fb_x_nxt);
            end
            flags_s1    <= cur_flags_c;
            hsync       <= flags_s1.hsync;
            vsync       <= flags_s1.vsync;
            de          <= flags_s1.de;
            frame_start <= flags_s1.frame_start;
            if (flags_s1.in_image) begin
                pixel_out <= fb_rd_data;
            end else if (flags_s1.de) begin
                pixel_out <= BORDER_COLOR;
            end else begin
                pixel_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Randomized scoreboard bench for framebuffer_scanout on a compact raster with random resets.
module tb_framebuffer_scanout;

    localparam int unsigned DW  = 10;
    localparam int unsigned DH  = 12;
    localparam int unsigned S   = 3;
    localparam int unsigned DB  = 16;
    localparam int unsigned AW  = $clog2(DW * DH);
    localparam int unsigned HA  = 40;
    localparam int unsigned HFP = 4;
    localparam int unsigned HS  = 6;
    localparam int unsigned HBP = 5;
    localparam int unsigned VA  = 30;
    localparam int unsigned VFP = 2;
    localparam int unsigned VS  = 2;
    localparam int unsigned VBP = 3;
    localparam int HT    = int'(HA + HFP + HS + HBP);
    localparam int VT    = int'(VA + VFP + VS + VBP);
    localparam int FRAME = HT * VT;
    localparam logic [DB-1:0] BORDER = 16'hBEEF;

    typedef struct packed {
        logic          hsync;
        logic          vsync;
        logic          de;
        logic          fs;
        logic [DB-1:0] px;
    } exp_t;

    localparam exp_t EXP_RST = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, fs: 1'b0, px: '0};

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] fb_rd_addr;
    logic [DB-1:0] fb_rd_data;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [DB-1:0] pixel_out;
    logic          frame_start;

    logic [DB-1:0] mem [DW*DH];
    exp_t          exp_q [$];
    int            cur_h = 0;
    int            cur_v = 0;
    int            rst_count = 0;
    bit            started = 1'b0;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    bit            have_fs = 1'b0;
    int            fs_cyc = 0;
    int            fs_rst_count = 0;

    framebuffer_scanout #(
        .DISPLAY_WIDTH         (DW),
        .DISPLAY_HEIGHT        (DH),
        .SCALE                 (S),
        .FRAMEBUFFER_DATA_BITS (DB),
        .FRAMEBUFFER_ADDR_BITS (AW),
        .H_ACTIVE              (HA),
        .H_FP                  (HFP),
        .H_SYNC                (HS),
        .H_BP                  (HBP),
        .V_ACTIVE              (VA),
        .V_FP                  (VFP),
        .V_SYNC                (VS),
        .V_BP                  (VBP),
        .BORDER_COLOR          (BORDER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fb_rd_addr  (fb_rd_addr),
        .fb_rd_data  (fb_rd_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pixel_out   (pixel_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Framebuffer memory with one clk read latency
    always @(posedge clk) begin
        if (int'(fb_rd_addr) < int'(DW * DH)) fb_rd_data <= mem[int'(fb_rd_addr)];
        else                                  fb_rd_data <= '0;
    end

    function automatic bit in_image(input int h, input int v);
        return (h < int'(HA)) && (v < int'(VA)) && (h / int'(S) < int'(DW)) && (v / int'(S) < int'(DH));
    endfunction

    function automatic exp_t expect_at(input int h, input int v);
        exp_t e;
        bit   act;
        act     = (h < int'(HA)) && (v < int'(VA));
        e.hsync = !((h >= int'(HA + HFP)) && (h < int'(HA + HFP + HS)));
        e.vsync = !((v >= int'(VA + VFP)) && (v < int'(VA + VFP + VS)));
        e.de    = act;
        e.fs    = (h == 0) && (v == 0);
        if (in_image(h, v)) e.px = mem[(v / int'(S)) * int'(DW) + h / int'(S)];
        else if (act)       e.px = BORDER;
        else                e.px = '0;
        return e;
    endfunction

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d, model h=%0d v=%0d)",
                     name, actual, expected, cyc, cur_h, cur_v);
        end
    endtask

    // Reference raster position; a reset cancels every output still in flight
    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            cur_h = 0;
            cur_v = 0;
            rst_count++;
            foreach (exp_q[i]) exp_q[i] = EXP_RST;
        end else begin
            cur_h++;
            if (cur_h == HT) begin
                cur_h = 0;
                cur_v++;
                if (cur_v == VT) cur_v = 0;
            end
        end
        exp_q.push_back(expect_at(cur_h, cur_v));
    end

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            cyc++;
            if (exp_q.size() == 0) begin
                check("queue_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("hsync", longint'(hsync), longint'(e.hsync));
                check("vsync", longint'(vsync), longint'(e.vsync));
                check("de", longint'(de), longint'(e.de));
                check("frame_start", longint'(frame_start), longint'(e.fs));
                check("pixel_out", longint'(pixel_out), longint'(e.px));
            end
            check("addr_in_range", longint'(int'(fb_rd_addr) < int'(DW * DH)), 1);
            if (in_image(cur_h, cur_v)) begin
                check("fb_rd_addr", longint'(fb_rd_addr),
                      longint'((cur_v / int'(S)) * int'(DW) + cur_h / int'(S)));
            end
            if (frame_start) begin
                if (have_fs && fs_rst_count == rst_count) begin
                    check("frame_period", longint'(cyc - fs_cyc), longint'(FRAME));
                end
                have_fs      = 1'b1;
                fs_cyc       = cyc;
                fs_rst_count = rst_count;
            end
        end
    end

    initial begin
        rst = 1'b1;
        foreach (mem[i]) mem[i] = DB'($urandom);
        exp_q.push_back(EXP_RST);
        exp_q.push_back(EXP_RST);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * FRAME + 100) @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(2500, 20)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            rst = 1'b0;
        end
        repeat (2 * FRAME + 200) @(negedge clk);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/framebuffer_scanout.md
FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 SHALL have parameter DISPLAY_WIDTH, default 100: framebuffer width in pixels.
REQ-002 SHALL have parameter DISPLAY_HEIGHT, default 100: framebuffer height in pixels.
REQ-003 SHALL have parameter SCALE, default 4: integer pixel replication factor, both axes, minimum 1.
REQ-004 SHALL have parameter FRAMEBUFFER_DATA_BITS, default 16: pixel word width.
REQ-005 SHALL have parameter FRAMEBUFFER_ADDR_BITS, default $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT): read address width.
REQ-006 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in clocks.
REQ-007 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
REQ-008 SHALL have parameter BORDER_COLOR, default 0: pixel value driven in active area outside the image.
REQ-009 clk  input  1  clock; all state changes on posedge.
REQ-010 rst  input  1  reset, synchronous, active-high.
REQ-011 fb_rd_addr  output  FRAMEBUFFER_ADDR_BITS  registered framebuffer read address.
REQ-012 fb_rd_data  input  FRAMEBUFFER_DATA_BITS  framebuffer read data, valid 1 clk after fb_rd_addr.
REQ-013 hsync  output  1  horizontal sync, active-low.
REQ-014 vsync  output  1  vertical sync, active-low.
REQ-015 de  output  1  data enable, high during active area.
REQ-016 pixel_out  output  FRAMEBUFFER_DATA_BITS  pixel value.
REQ-017 frame_start  output  1  one-clk pulse with the output of position (0,0).

Function
REQ-018 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params) and wrap to 0; v_cnt SHALL increment on h wrap, 0..V_TOTAL-1, wrap to 0.
REQ-019 Active area SHALL be h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-020 hsync SHALL be low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise with V params on v_cnt; polarity independent of de.
REQ-021 fb_x = h_cnt/SCALE, fb_y = v_cnt/SCALE SHALL be tracked with sub-pixel counters; no divider, no multiplier.
REQ-022 fb_rd_addr SHALL equal fb_y*DISPLAY_WIDTH + fb_x, maintained incrementally (row base += DISPLAY_WIDTH per fb_y step), in the same cycle as the (h_cnt, v_cnt) it belongs to.
REQ-023 in_image SHALL be active and fb_x < DISPLAY_WIDTH and fb_y < DISPLAY_HEIGHT; image origin top-left; if SCALE*size exceeds active area, image is clipped.
REQ-024 When in_image is false, fb_rd_addr SHALL hold its last value (always in range, never >= DISPLAY_WIDTH*DISPLAY_HEIGHT).
REQ-025 hsync, vsync, de, frame_start, in_image SHALL pass a 2-stage pipeline so all outputs for position (h,v) appear exactly 2 clk after the counters hold (h,v).
REQ-026 pixel_out SHALL be registered: fb_rd_data if in_image, BORDER_COLOR if de and not in_image, 0 if not de.
REQ-027 frame_start SHALL pulse exactly once per frame, one clk, coincident with de of position (0,0).
REQ-028 Frame period SHALL be exactly H_TOTAL*V_TOTAL clk (default 800*525 = 420000).

Reset
REQ-029 On rst: h_cnt, v_cnt, sub-counters, row base, fb_rd_addr = 0; hsync = 1, vsync = 1, de = 0, pixel_out = 0, frame_start = 0; pipeline flushed to these values.
REQ-030 rst mid-frame SHALL abort the frame; counters hold (0,0) in the first clk after rst deasserts; frame_start pulses 2 clk later; no partial sync pulse is stretched.

Structure
REQ-031 Timing defaults and the shared color type SHALL live in the shared video package alongside point/triangle/color typedefs.
REQ-032 One sub-module, sync_timing_gen (h/v counters, active flag, raw syncs), SHALL be instantiated; address generation and pixel pipeline stay in framebuffer_scanout.

Verification
REQ-033 Default params, framebuffer model returns data = address: output at h=5,v=0 -> pixel_out = 1; at h=0,v=4 -> pixel_out = 100; at h=399,v=399 -> pixel_out = 9999.
REQ-034 h=400,v=0 and h=0,v=400 (outside image, active) -> de = 1, pixel_out = BORDER_COLOR; h=640 -> de = 0, pixel_out = 0.
REQ-035 Free run -> hsync low for 96 clk starting at output of h=656; vsync low for 2 lines starting at v=490; frame_start spacing 420000 clk.
REQ-036 Release rst -> frame_start high exactly 2 clk after first clk with rst low; hsync = vsync = 1, de = 0 during rst.
REQ-037 Assert rst 1 clk at h=300,v=200 -> next frame_start 2 clk after deassert; fb_rd_addr never exceeds 9999 across 3 frames.
